spi_reg_responder: RTL and testbench

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

---
 rtl/spi_resp_pkg.sv | 20 ++
 rtl/spi_resp_sync.sv | 27 ++
 rtl/spi_reg_responder.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared definitions for the SPI register responder: FSM states,
// command-byte field positions and the synchroniser depth.
package spi_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA,
        DRAIN
    } state_t;

    // Command byte is {rw, addr[6:0]}; rw=1 selects a read.
    localparam int RW_BIT      = 7;
    localparam int CMD_BITS    = 8;

    // Flops in each asynchronous-input synchroniser.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_resp_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// RESET_VAL is the value the chain holds while reset is applied.
module spi_resp_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    import spi_resp_pkg::*;

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous bit through the synchroniser chain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI (mode 0) register-access responder running entirely on iCLK.
// A frame is a command byte {rw, addr} followed by one DATA_W-bit word,
// MSB first. Define SPI_RESP_BURST_EN to allow several words per frame
// with an auto-incrementing register address.
module spi_reg_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iSCK,
    input  logic              iCSn,
    input  logic              iMOSI,
    output logic              oMISO,
    output logic              oMISO_OE,
    output logic [ADDR_W-1:0] oREG_ADDR,
    output logic [DATA_W-1:0] oREG_WRDATA,
    output logic              oREG_WRITE,
    output logic              oREG_READ,
    input  logic [DATA_W-1:0] iREG_RDDATA
);
    import spi_resp_pkg::*;

`ifdef SPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int              CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sck_s, cs_s, mosi_s;
    logic sck_prev, cs_prev, cs_armed;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    state_t state, next_state;
    logic              cmd_done, word_done;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx;
    logic [DATA_W-1:0] tx;
    logic [7:0]        cmd_byte;
    logic              read_pend;

    // The CS chain resets to "selected" so that a host already holding
    // iCSn low across reset never produces a falling edge; the frame in
    // flight is therefore ignored until CS is released and asserted again.
    spi_resp_sync #(.RESET_VAL(1'b0)) u_sync_sck  (.clk(iCLK), .rst_n(iRESETn), .d(iSCK),  .q(sck_s));
    spi_resp_sync #(.RESET_VAL(1'b0)) u_sync_cs   (.clk(iCLK), .rst_n(iRESETn), .d(iCSn),  .q(cs_s));
    spi_resp_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(iCLK), .rst_n(iRESETn), .d(iMOSI), .q(mosi_s));

    // Delayed copies of the synchronised SCK and CS for edge detection.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            sck_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign cmd_byte = {rx[CMD_BITS-2:0], mosi_s};

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus command/word completion flags.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        cmd_done   = 1'b0;
        word_done  = 1'b0;
        if (cs_rise) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) next_state = CMD;
                end
                CMD: begin
                    if (sck_rise && bit_cnt == CMD_LAST) begin
                        cmd_done   = 1'b1;
                        next_state = cmd_byte[RW_BIT] ? RD_DATA : WR_DATA;
                    end
                end
                WR_DATA, RD_DATA: begin
                    if (sck_rise && bit_cnt == DATA_LAST) begin
                        word_done  = 1'b1;
                        next_state = BURST ? state : DRAIN;
                    end
                end
                DRAIN: begin
                    next_state = DRAIN;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Shift registers, bit counter, register-bus strobes and MISO.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            read_pend   <= 1'b0;
            cs_armed    <= 1'b0;
            oMISO       <= 1'b0;
            oMISO_OE    <= 1'b0;
            oREG_ADDR   <= '0;
            oREG_WRDATA <= '0;
            oREG_WRITE  <= 1'b0;
            oREG_READ   <= 1'b0;
        end else begin
            oREG_WRITE <= 1'b0;
            oREG_READ  <= 1'b0;
            read_pend  <= oREG_READ;
            cs_armed   <= cs_armed | cs_s;
            oMISO_OE   <= ~cs_s & cs_armed;

            if (sck_rise && (state == CMD || state == WR_DATA || state == RD_DATA)) begin
                bit_cnt <= bit_cnt + 1'b1;
                rx      <= {rx[DATA_W-3:0], mosi_s};
            end
            if ((state == IDLE && cs_fall) || cs_rise) begin
                bit_cnt <= '0;
            end

            if (cmd_done) begin
                bit_cnt   <= '0;
                oREG_ADDR <= cmd_byte[ADDR_W-1:0];
                oREG_READ <= cmd_byte[RW_BIT];
            end

            if (word_done) begin
                bit_cnt <= '0;
                if (state == WR_DATA) begin
                    oREG_WRITE  <= 1'b1;
                    oREG_WRDATA <= {rx, mosi_s};
                end else if (BURST) begin
                    // Next read goes out at once so its data is ready before the next falling edge.
                    oREG_READ <= 1'b1;
                    oREG_ADDR <= oREG_ADDR + 1'b1;
                end
            end

            // Burst writes advance the address only after the strobe has used it.
            if (BURST && oREG_WRITE) begin
                oREG_ADDR <= oREG_ADDR + 1'b1;
            end

            if (read_pend) begin
                tx <= iREG_RDDATA;
            end else if (state == RD_DATA && sck_fall) begin
                oMISO <= tx[DATA_W-1];
                tx    <= {tx[DATA_W-2:0], 1'b0};
            end
            if (state != RD_DATA) begin
                oMISO <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: a bit-banged SPI host, a register
// file that answers reads one cycle after oREG_READ, and a strobe monitor.
module tb_spi_reg_responder;
    import spi_resp_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRESETn = 1'b0;
    logic        iSCK = 1'b0;
    logic        iCSn = 1'b1;
    logic        iMOSI = 1'b0;
    logic        oMISO, oMISO_OE, oREG_WRITE, oREG_READ;
    logic [6:0]  oREG_ADDR;
    logic [31:0] oREG_WRDATA;
    logic [31:0] iREG_RDDATA;

    int errors = 0;
    int checks = 0;
    int half = 6;

    logic [31:0] mem [128];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap = 0;
    logic [6:0]  wr_addr_log [16];
    logic [31:0] wr_data_log [16];
    logic [6:0]  last_rd_addr = '0;

    logic        oe_mid;
    logic        snap_miso, snap_oe, snap_wr, snap_rd;
    logic [6:0]  snap_addr;
    logic [31:0] snap_wrdata;
    state_t      snap_state;

    always #5 iCLK = ~iCLK;

    spi_reg_responder #(.ADDR_W(7), .DATA_W(32)) dut (
        .iCLK       (iCLK),
        .iRESETn    (iRESETn),
        .iSCK       (iSCK),
        .iCSn       (iCSn),
        .iMOSI      (iMOSI),
        .oMISO      (oMISO),
        .oMISO_OE   (oMISO_OE),
        .oREG_ADDR  (oREG_ADDR),
        .oREG_WRDATA(oREG_WRDATA),
        .oREG_WRITE (oREG_WRITE),
        .oREG_READ  (oREG_READ),
        .iREG_RDDATA(iREG_RDDATA)
    );

    // Register file: data is valid only in the cycle after oREG_READ.
    always @(posedge iCLK) begin
        if (oREG_WRITE) mem[oREG_ADDR] <= oREG_WRDATA;
        iREG_RDDATA <= oREG_READ ? mem[oREG_ADDR] : 32'h0;
    end

    // Strobe monitor sampled mid-cycle.
    always @(negedge iCLK) begin
        if (oREG_WRITE) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = oREG_ADDR;
                wr_data_log[wr_cnt] = oREG_WRDATA;
            end
            wr_cnt++;
        end
        if (oREG_READ) begin
            last_rd_addr = oREG_ADDR;
            rd_cnt++;
        end
        if (oREG_WRITE && oREG_READ) overlap++;
    end

    // One SPI mode-0 frame: command byte then nbits of wdata (MSB first).
    // rst_bit >= 0 pulses iRESETn for one cycle during that data bit.
    task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] wdata, input int nbits,
                             input int rst_bit, output logic [63:0] rdata);
        rdata = '0;
        @(negedge iCLK);
        iCSn = 1'b0;
        repeat (6) @(negedge iCLK);
        for (int i = 0; i < 8 + nbits; i++) begin
            iMOSI = (i < 8) ? cmd[7-i] : wdata[63-(i-8)];
            if (rst_bit >= 0 && i == rst_bit + 8) begin
                @(negedge iCLK);
                iRESETn = 1'b0;
                @(negedge iCLK);
                snap_miso   = oMISO;
                snap_oe     = oMISO_OE;
                snap_wr     = oREG_WRITE;
                snap_rd     = oREG_READ;
                snap_addr   = oREG_ADDR;
                snap_wrdata = oREG_WRDATA;
                snap_state  = dut.state;
                iRESETn = 1'b1;
            end
            repeat (half) @(negedge iCLK);
            if (i >= 8) rdata[63-(i-8)] = oMISO;
            if (i == 8) oe_mid = oMISO_OE;
            iSCK = 1'b1;
            repeat (half) @(negedge iCLK);
            iSCK = 1'b0;
        end
        repeat (half) @(negedge iCLK);
        iCSn  = 1'b1;
        iMOSI = 1'b0;
        repeat (12) @(negedge iCLK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iCLK);
        checks++; if (oMISO !== 1'b0)       begin errors++; $display("FAIL reset_miso: got %0b want 0", oMISO); end
        checks++; if (oMISO_OE !== 1'b0)    begin errors++; $display("FAIL reset_oe: got %0b want 0", oMISO_OE); end
        checks++; if (oREG_WRITE !== 1'b0)  begin errors++; $display("FAIL reset_write: got %0b want 0", oREG_WRITE); end
        checks++; if (oREG_READ !== 1'b0)   begin errors++; $display("FAIL reset_read: got %0b want 0", oREG_READ); end
        checks++; if (oREG_ADDR !== 7'h00)  begin errors++; $display("FAIL reset_addr: got %h want 00", oREG_ADDR); end
        checks++; if (oREG_WRDATA !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", oREG_WRDATA); end
        checks++; if (dut.state !== IDLE)   begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
        iRESETn = 1'b1;
        repeat (6) @(negedge iCLK);
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        logic [63:0] rd;
        spi_frame(8'h05, {32'hDEADBEEF, 32'h0}, 32, -1, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0] !== 7'h05) begin errors++; $display("FAIL write_addr: got %h want 05", wr_addr_log[w0]); end
        checks++; if (wr_data_log[w0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h want deadbeef", wr_data_log[w0]); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL write_no_read: got %0d want 0", rd_cnt - r0); end
        checks++; if (oe_mid !== 1'b1) begin errors++; $display("FAIL oe_in_frame: got %0b want 1", oe_mid); end
        checks++; if (oMISO_OE !== 1'b0) begin errors++; $display("FAIL oe_after_frame: got %0b want 0", oMISO_OE); end
    endtask

    task automatic test_read();
        int w0, r0;
        logic [63:0] rd;
        spi_frame(8'h05, {32'h12345678, 32'h0}, 32, -1, rd);
        w0 = wr_cnt;
        r0 = rd_cnt;
        spi_frame(8'h85, 64'h0, 32, -1, rd);
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_count: got %0d want 1", rd_cnt - r0); end
        checks++; if (last_rd_addr !== 7'h05) begin errors++; $display("FAIL read_addr: got %h want 05", last_rd_addr); end
        checks++; if (rd[63:32] !== 32'h12345678) begin errors++; $display("FAIL read_miso: got %h want 12345678", rd[63:32]); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL read_no_write: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_partial();
        int w0 = wr_cnt;
        logic [63:0] rd;
        spi_frame(8'h10, {32'hA5A50F0F, 32'h0}, 20, -1, rd);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL partial_no_write: got %0d want 0", wr_cnt - w0); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL partial_state: got %0d want IDLE", dut.state); end
        w0 = wr_cnt;
        spi_frame(8'h10, {32'hCAFEF00D, 32'h0}, 32, -1, rd);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL partial_next_count: got %0d want 1", wr_cnt - w0); end
        checks++; if (wr_data_log[w0] !== 32'hCAFEF00D || wr_addr_log[w0] !== 7'h10) begin
            errors++; $display("FAIL partial_next_word: got %h@%h want cafef00d@10", wr_data_log[w0], wr_addr_log[w0]);
        end
    endtask

    task automatic test_reset_mid();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        logic [63:0] rd;
        spi_frame(8'h21, {32'h13572468, 32'h0}, 32, 11, rd);
        checks++; if (snap_miso !== 1'b0)     begin errors++; $display("FAIL rstmid_miso: got %0b want 0", snap_miso); end
        checks++; if (snap_oe !== 1'b0)       begin errors++; $display("FAIL rstmid_oe: got %0b want 0", snap_oe); end
        checks++; if (snap_wr !== 1'b0 || snap_rd !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %0b%0b want 00", snap_wr, snap_rd); end
        checks++; if (snap_addr !== 7'h00)    begin errors++; $display("FAIL rstmid_addr: got %h want 00", snap_addr); end
        checks++; if (snap_wrdata !== 32'h0)  begin errors++; $display("FAIL rstmid_wrdata: got %h want 0", snap_wrdata); end
        checks++; if (snap_state !== IDLE)    begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", snap_state); end
        checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
            errors++; $display("FAIL rstmid_no_strobe: got wr=%0d rd=%0d want 0 0", wr_cnt - w0, rd_cnt - r0);
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_idle: got %0d want IDLE", dut.state); end
        w0 = wr_cnt;
        spi_frame(8'h21, {32'h0BADCAFE, 32'h0}, 32, -1, rd);
        checks++; if (wr_cnt - w0 !== 1 || wr_data_log[w0] !== 32'h0BADCAFE || wr_addr_log[w0] !== 7'h21) begin
            errors++; $display("FAIL rstmid_recover: got n=%0d %h@%h want 1 0badcafe@21", wr_cnt - w0, wr_data_log[w0], wr_addr_log[w0]);
        end
    endtask

    task automatic test_burst();
        int w0 = wr_cnt;
        logic [63:0] rd;
        spi_frame(8'h7F, {32'h11112222, 32'h33334444}, 64, -1, rd);
`ifdef SPI_RESP_BURST_EN
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL burst_count: got %0d want 2", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0] !== 7'h7F || wr_data_log[w0] !== 32'h11112222) begin
            errors++; $display("FAIL burst_word0: got %h@%h want 11112222@7f", wr_data_log[w0], wr_addr_log[w0]);
        end
        checks++; if (wr_addr_log[w0+1] !== 7'h00 || wr_data_log[w0+1] !== 32'h33334444) begin
            errors++; $display("FAIL burst_word1: got %h@%h want 33334444@00", wr_data_log[w0+1], wr_addr_log[w0+1]);
        end
`else
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0] !== 7'h7F || wr_data_log[w0] !== 32'h11112222) begin
            errors++; $display("FAIL single_word0: got %h@%h want 11112222@7f", wr_data_log[w0], wr_addr_log[w0]);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_mem [128];
        logic [6:0]  written [8];
        int          nw = 0;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [63:0] rd;
        int          w0, r0;
        half = 5;
        for (int i = 0; i < 8; i++) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            if (nw == 0 || $urandom_range(0, 1) == 0) begin
                addr = 7'($urandom_range(0, 127));
                data = $urandom;
                spi_frame({1'b0, addr}, {data, 32'h0}, 32, -1, rd);
                exp_mem[addr] = data;
                written[nw] = addr;
                nw++;
                checks++; if (wr_cnt - w0 !== 1 || wr_addr_log[w0] !== addr || wr_data_log[w0] !== data) begin
                    errors++; $display("FAIL rand_write%0d: got n=%0d %h@%h want 1 %h@%h", i, wr_cnt - w0, wr_data_log[w0], wr_addr_log[w0], data, addr);
                end
            end else begin
                addr = written[$urandom_range(0, nw - 1)];
                spi_frame({1'b1, addr}, 64'h0, 32, -1, rd);
                checks++; if (rd_cnt - r0 !== 1 || last_rd_addr !== addr || rd[63:32] !== exp_mem[addr]) begin
                    errors++; $display("FAIL rand_read%0d: got n=%0d %h@%h want 1 %h@%h", i, rd_cnt - r0, rd[63:32], last_rd_addr, exp_mem[addr], addr);
                end
            end
        end
        half = 6;
    endtask

    task automatic test_exclusive();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_partial();
        test_reset_mid();
        test_burst();
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
